// File: rtl/axi_ram_lat.sv
// AXI4 slave RAM with programmable read latency behind a credit-limited read-data FIFO,
// WRAP bursts, non-power-of-two depth with SLVERR on out-of-range beats, and WLAST checking.
module axi_ram_lat #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 16,
   parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH      = 8,
   parameter int unsigned MEM_WORDS     = 4096,
   parameter int unsigned READ_LATENCY  = 4,
   parameter int unsigned RD_FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ID_WIDTH-1:0]   s_axi_awid_i,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr_i,
   input  logic [7:0]            s_axi_awlen_i,
   input  logic [2:0]            s_axi_awsize_i,
   input  logic [1:0]            s_axi_awburst_i,
   input  logic                  s_axi_awlock_i,
   input  logic [3:0]            s_axi_awcache_i,
   input  logic [2:0]            s_axi_awprot_i,
   input  logic                  s_axi_awvalid_i,
   output logic                  s_axi_awready_o,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata_i,
   input  logic [STRB_WIDTH-1:0] s_axi_wstrb_i,
   input  logic                  s_axi_wlast_i,
   input  logic                  s_axi_wvalid_i,
   output logic                  s_axi_wready_o,
   output logic [ID_WIDTH-1:0]   s_axi_bid_o,
   output logic [1:0]            s_axi_bresp_o,
   output logic                  s_axi_bvalid_o,
   input  logic                  s_axi_bready_i,
   input  logic [ID_WIDTH-1:0]   s_axi_arid_i,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr_i,
   input  logic [7:0]            s_axi_arlen_i,
   input  logic [2:0]            s_axi_arsize_i,
   input  logic [1:0]            s_axi_arburst_i,
   input  logic                  s_axi_arlock_i,
   input  logic [3:0]            s_axi_arcache_i,
   input  logic [2:0]            s_axi_arprot_i,
   input  logic                  s_axi_arvalid_i,
   output logic                  s_axi_arready_o,
   output logic [ID_WIDTH-1:0]   s_axi_rid_o,
   output logic [DATA_WIDTH-1:0] s_axi_rdata_o,
   output logic [1:0]            s_axi_rresp_o,
   output logic                  s_axi_rlast_o,
   output logic                  s_axi_rvalid_o,
   input  logic                  s_axi_rready_i
);

   localparam int unsigned BYTE_SH = $clog2(STRB_WIDTH);
   localparam int unsigned WORD_W  = ADDR_WIDTH - BYTE_SH;
   localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned PTR_W   = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W   = $clog2(RD_FIFO_DEPTH + 1);
   localparam int unsigned CW1     = CNT_W + 1;

   typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_BURST} rstate_e;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } rbeat_t;

   function automatic logic [2:0] cap_size(input logic [2:0] size);
      return (size > 3'(BYTE_SH)) ? 3'(BYTE_SH) : size;
   endfunction

   // WRAP only for lengths 2/4/8/16; other lengths fall back to INCR
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [7:0] len,
                                                       input logic [2:0] sz,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] mask;
      incr = ADDR_WIDTH'(1) << sz;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
      if (burst == 2'b00)
         return addr;
      else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         return (addr & ~mask) | ((addr + incr) & mask);
      else
         return addr + incr;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   // ---------------- write channel ----------------
   wstate_e               w_state_q, w_state_d;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [2:0]            wsize_q, wsize_d;
   logic [1:0]            wburst_q, wburst_d;
   logic                  werr_q, werr_d;
   logic [WORD_W-1:0]     w_word_c;
   logic                  w_in_range_c, w_last_beat_c, w_beat_err_c, mem_we_c;

   assign w_word_c      = waddr_q[ADDR_WIDTH-1:BYTE_SH];
   assign w_in_range_c  = 32'(w_word_c) < MEM_WORDS;
   assign w_last_beat_c = (wbeat_q == wlen_q);
   assign w_beat_err_c  = !w_in_range_c || (s_axi_wlast_i != w_last_beat_c);

   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      bid_d     = bid_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wsize_d   = wsize_q;
      wburst_d  = wburst_q;
      wbeat_d   = wbeat_q;
      werr_d    = werr_q;
      mem_we_c  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (awready_q && s_axi_awvalid_i) begin
               awready_d = 1'b0;
               wready_d  = 1'b1;
               bid_d     = s_axi_awid_i;
               waddr_d   = s_axi_awaddr_i;
               wlen_d    = s_axi_awlen_i;
               wsize_d   = cap_size(s_axi_awsize_i);
               wburst_d  = s_axi_awburst_i;
               wbeat_d   = 8'd0;
               werr_d    = 1'b0;
               w_state_d = W_BURST;
            end
         end
         W_BURST: begin
            if (wready_q && s_axi_wvalid_i) begin
               mem_we_c = w_in_range_c && rst_n;
               waddr_d  = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
               wbeat_d  = wbeat_q + 8'd1;
               werr_d   = werr_q | w_beat_err_c;
               if (w_last_beat_c) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = (werr_q | w_beat_err_c) ? 2'b10 : 2'b00;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (s_axi_bready_i) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         bid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         wbeat_q   <= '0;
         werr_q    <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         bid_q     <= bid_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         wbeat_q   <= wbeat_d;
         werr_q    <= werr_d;
      end
   end

   // Memory is never reset; byte lanes follow WSTRB
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            if (s_axi_wstrb_i[b]) mem_q[IDX_W'(w_word_c)][b*8 +: 8] <= s_axi_wdata_i[b*8 +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   rstate_e               r_state_q, r_state_d;
   logic                  arready_q, arready_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic [2:0]            rsize_q, rsize_d;
   logic [1:0]            rburst_q, rburst_d;
   logic [WORD_W-1:0]     r_word_c;
   logic                  r_in_range_c, issue_c, push_c, pop_c;
   logic [CW1-1:0]        pipe_cnt_c, in_flight_c;
   rbeat_t                issue_beat_c;
   logic [READ_LATENCY-1:0] pipe_vld_q;
   rbeat_t                pipe_q [READ_LATENCY];
   rbeat_t                fifo_q [RD_FIFO_DEPTH];
   logic [PTR_W-1:0]      fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
   logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic                  rvalid_q, rvalid_d;
   rbeat_t                rhead_q, rhead_d;

   assign r_word_c     = raddr_q[ADDR_WIDTH-1:BYTE_SH];
   assign r_in_range_c = 32'(r_word_c) < MEM_WORDS;

   // Credits count both queued and in-flight beats so the FIFO can never overflow
   always_comb begin
      pipe_cnt_c = '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_cnt_c = pipe_cnt_c + CW1'(pipe_vld_q[i]);
      in_flight_c = CW1'(fifo_cnt_q) + pipe_cnt_c;
      issue_c     = (r_state_q == R_BURST) && (in_flight_c < CW1'(RD_FIFO_DEPTH));
   end

   always_comb begin
      issue_beat_c.id   = rid_q;
      issue_beat_c.data = r_in_range_c ? mem_q[IDX_W'(r_word_c)] : '0;
      issue_beat_c.resp = r_in_range_c ? 2'b00 : 2'b10;
      issue_beat_c.last = (rbeat_q == rlen_q);
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rid_d     = rid_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rbeat_d   = rbeat_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (arready_q && s_axi_arvalid_i) begin
               arready_d = 1'b0;
               rid_d     = s_axi_arid_i;
               raddr_d   = s_axi_araddr_i;
               rlen_d    = s_axi_arlen_i;
               rsize_d   = cap_size(s_axi_arsize_i);
               rburst_d  = s_axi_arburst_i;
               rbeat_d   = 8'd0;
               r_state_d = R_BURST;
            end
         end
         R_BURST: begin
            if (issue_c) begin
               raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
               rbeat_d = rbeat_q + 8'd1;
               if (rbeat_q == rlen_q) begin
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rbeat_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rid_q     <= rid_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rbeat_q   <= rbeat_d;
      end
   end

   // Latency pipe: memory is sampled at issue, so a same-cycle write is not seen
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_vld_q <= '0;
      end else begin
         pipe_vld_q[0] <= issue_c;
         for (int i = 1; i < int'(READ_LATENCY); i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_q[0] <= issue_beat_c;
      for (int i = 1; i < int'(READ_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
   end

   assign push_c = pipe_vld_q[READ_LATENCY-1];
   assign pop_c  = rvalid_q && s_axi_rready_i;

   // Head of FIFO is kept in a register so R outputs come straight from flops
   always_comb begin
      fifo_wptr_d = fifo_wptr_q;
      fifo_rptr_d = fifo_rptr_q;
      if (push_c) fifo_wptr_d = (fifo_wptr_q == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : fifo_wptr_q + PTR_W'(1);
      if (pop_c)  fifo_rptr_d = (fifo_rptr_q == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : fifo_rptr_q + PTR_W'(1);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      rvalid_d   = (fifo_cnt_d != '0);
      if (push_c && (fifo_wptr_q == fifo_rptr_d)) rhead_d = pipe_q[READ_LATENCY-1];
      else                                        rhead_d = fifo_q[fifo_rptr_d];
      if (!rvalid_d) rhead_d = '0;
   end

   always_ff @(posedge clk) begin
      if (push_c) fifo_q[fifo_wptr_q] <= pipe_q[READ_LATENCY-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_wptr_q <= '0;
         fifo_rptr_q <= '0;
         fifo_cnt_q  <= '0;
         rvalid_q    <= 1'b0;
         rhead_q     <= '0;
      end else begin
         fifo_wptr_q <= fifo_wptr_d;
         fifo_rptr_q <= fifo_rptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         rvalid_q    <= rvalid_d;
         rhead_q     <= rhead_d;
      end
   end

   logic unused_c;
   assign unused_c = ^{s_axi_awlock_i, s_axi_awcache_i, s_axi_awprot_i,
                       s_axi_arlock_i, s_axi_arcache_i, s_axi_arprot_i};

   assign s_axi_awready_o = awready_q;
   assign s_axi_wready_o  = wready_q;
   assign s_axi_bid_o     = bid_q;
   assign s_axi_bresp_o   = bresp_q;
   assign s_axi_bvalid_o  = bvalid_q;
   assign s_axi_arready_o = arready_q;
   assign s_axi_rid_o     = rhead_q.id;
   assign s_axi_rdata_o   = rhead_q.data;
   assign s_axi_rresp_o   = rhead_q.resp;
   assign s_axi_rlast_o   = rhead_q.last;
   assign s_axi_rvalid_o  = rvalid_q;

endmodule

// File: tb/tb_axi_ram_lat.sv
// Directed self-checking bench for axi_ram_lat (MEM_WORDS=1000, READ_LATENCY=4, FIFO depth 8).
module tb_axi_ram_lat;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  awid, arid, bid, rid;
   logic [15:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;

   int errors = 0;
   int checks = 0;

   logic [31:0] wbuf [16];
   logic [31:0] rdat [32];
   logic [1:0]  rrsp [32];
   logic        rlst [32];
   logic [7:0]  rids [32];
   int          rn;

   always #5 clk = ~clk;

   axi_ram_lat #(.MEM_WORDS(1000)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen),
      .s_axi_awsize_i(awsize), .s_axi_awburst_i(awburst), .s_axi_awlock_i(1'b0),
      .s_axi_awcache_i(4'd0), .s_axi_awprot_i(3'd0), .s_axi_awvalid_i(awvalid),
      .s_axi_awready_o(awready),
      .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast),
      .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
      .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
      .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen),
      .s_axi_arsize_i(arsize), .s_axi_arburst_i(arburst), .s_axi_arlock_i(1'b0),
      .s_axi_arcache_i(4'd0), .s_axi_arprot_i(3'd0), .s_axi_arvalid_i(arvalid),
      .s_axi_arready_o(arready),
      .s_axi_rid_o(rid), .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rlast_o(rlast),
      .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic aw_send(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] id);
      int n = 0;
      awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awid = id; awvalid = 1'b1;
      while (awready !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) begin checks++; errors++; $display("FAIL aw_timeout got=no AWREADY exp=AWREADY"); end
      step();
      awvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] id);
      int n = 0;
      araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arid = id; arvalid = 1'b1;
      while (arready !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) begin checks++; errors++; $display("FAIL ar_timeout got=no ARREADY exp=ARREADY"); end
      step();
      arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0] id, input logic [3:0] strb, input int early,
                           output logic [1:0] resp, output logic [7:0] rsp_id);
      int n;
      aw_send(addr, len, burst, id);
      for (int i = 0; i <= int'(len); i++) begin
         wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len)) || (i == early); wvalid = 1'b1;
         n = 0;
         while (wready !== 1'b1 && n < 100) begin step(); n++; end
         if (n >= 100) begin checks++; errors++; $display("FAIL w_timeout got=no WREADY exp=WREADY"); end
         step();
      end
      wvalid = 1'b0; wlast = 1'b0;
      bready = 1'b1;
      n = 0;
      while (bvalid !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) begin checks++; errors++; $display("FAIL b_timeout got=no BVALID exp=BVALID"); end
      resp = bresp; rsp_id = bid;
      step();
      bready = 1'b0;
   endtask

   task automatic collect(input int nbeats);
      int n;
      rready = 1'b1;
      rn = 0;
      for (int i = 0; i < nbeats; i++) begin
         n = 0;
         while (rvalid !== 1'b1 && n < 100) begin step(); n++; end
         if (n >= 100) begin
            checks++; errors++;
            $display("FAIL r_timeout got=%0d beats exp=%0d beats", rn, nbeats);
            break;
         end
         rdat[rn] = rdata; rrsp[rn] = rresp; rlst[rn] = rlast; rids[rn] = rid; rn++;
         step();
      end
      rready = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [7:0] id, output int lat);
      ar_send(addr, len, burst, id);
      lat = 0;
      while (rvalid !== 1'b1 && lat < 100) begin step(); lat++; end
      collect(int'(len) + 1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      repeat (3) step();
      checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready got=%b exp=0", awready); end
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready got=%b exp=0", arready); end
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready got=%b exp=0", wready); end
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got=%b exp=0", bvalid); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      checks++; if (bresp !== 2'b00 || rresp !== 2'b00) begin errors++; $display("FAIL rst_resp got=%b/%b exp=00/00", bresp, rresp); end
      rst_n = 1'b1;
      step();
      checks++; if (awready !== 1'b1) begin errors++; $display("FAIL rel_awready got=%b exp=1", awready); end
      checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rel_arready got=%b exp=1", arready); end
   endtask

   task automatic test_incr();
      logic [1:0] r; logic [7:0] id; int lat;
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
      do_write(16'h0010, 8'd3, 2'b01, 8'h11, 4'hF, -1, r, id);
      checks++; if (r !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%b exp=00", r); end
      checks++; if (id !== 8'h11) begin errors++; $display("FAIL incr_bid got=%h exp=11", id); end
      do_read(16'h0010, 8'd3, 2'b01, 8'h22, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL incr_latency got=%0d exp=5", lat); end
      checks++; if (rn !== 4) begin errors++; $display("FAIL incr_beats got=%0d exp=4", rn); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdat[i] !== 32'hA0 + 32'(i) || rrsp[i] !== 2'b00 || rlst[i] !== (i == 3) || rids[i] !== 8'h22) begin
            errors++;
            $display("FAIL incr_beat%0d got=%h/%b/%b/%h exp=%h/00/%b/22", i, rdat[i], rrsp[i], rlst[i], rids[i],
                     32'hA0 + 32'(i), (i == 3));
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0] r; logic [7:0] id; int lat;
      logic [31:0] exp_incr [4];
      exp_incr[0] = 32'hB2; exp_incr[1] = 32'hB3; exp_incr[2] = 32'hB0; exp_incr[3] = 32'hB1;
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
      do_write(16'h0018, 8'd3, 2'b10, 8'h5A, 4'hF, -1, r, id);
      checks++; if (r !== 2'b00) begin errors++; $display("FAIL wrap_bresp got=%b exp=00", r); end
      do_read(16'h0010, 8'd3, 2'b01, 8'h01, lat);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdat[i] !== exp_incr[i]) begin errors++; $display("FAIL wrap_incr_rd%0d got=%h exp=%h", i, rdat[i], exp_incr[i]); end
      end
      do_read(16'h0018, 8'd3, 2'b10, 8'h02, lat);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdat[i] !== 32'hB0 + 32'(i) || rlst[i] !== (i == 3)) begin
            errors++; $display("FAIL wrap_rd%0d got=%h/%b exp=%h/%b", i, rdat[i], rlst[i], 32'hB0 + 32'(i), (i == 3));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] r; logic [7:0] id;
      for (int i = 0; i < 16; i++) wbuf[i] = 32'hC000_0000 + 32'(i);
      do_write(16'h0100, 8'd15, 2'b01, 8'h03, 4'hF, -1, r, id);
      checks++; if (r !== 2'b00) begin errors++; $display("FAIL bp_bresp got=%b exp=00", r); end
      rready = 1'b0;
      ar_send(16'h0100, 8'd15, 2'b01, 8'h33);
      repeat (30) step();
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL bp_stalled got=arready %b exp=0", arready); end
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hC000_0000) begin
         errors++; $display("FAIL bp_head got=%b/%h exp=1/c0000000", rvalid, rdata);
      end
      collect(16);
      checks++; if (rn !== 16) begin errors++; $display("FAIL bp_beats got=%0d exp=16", rn); end
      for (int i = 0; i < rn; i++) begin
         checks++;
         if (rdat[i] !== 32'hC000_0000 + 32'(i) || rlst[i] !== (i == 15) || rids[i] !== 8'h33) begin
            errors++; $display("FAIL bp_beat%0d got=%h/%b/%h exp=%h/%b/33", i, rdat[i], rlst[i], rids[i],
                                32'hC000_0000 + 32'(i), (i == 15));
         end
      end
      repeat (10) step();
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat got=rvalid %b exp=0", rvalid); end
   endtask

   task automatic test_out_of_range();
      logic [1:0] r; logic [7:0] id; int lat;
      wbuf[0] = 32'hD0; wbuf[1] = 32'hD1;
      do_write(16'h0F9C, 8'd1, 2'b01, 8'h44, 4'hF, -1, r, id);
      checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got=%b exp=10", r); end
      checks++; if (id !== 8'h44) begin errors++; $display("FAIL oor_bid got=%h exp=44", id); end
      do_read(16'h0F9C, 8'd1, 2'b01, 8'h55, lat);
      checks++; if (rdat[0] !== 32'hD0 || rrsp[0] !== 2'b00) begin
         errors++; $display("FAIL oor_beat0 got=%h/%b exp=000000d0/00", rdat[0], rrsp[0]);
      end
      checks++; if (rdat[1] !== 32'h0 || rrsp[1] !== 2'b10 || rlst[1] !== 1'b1) begin
         errors++; $display("FAIL oor_beat1 got=%h/%b/%b exp=00000000/10/1", rdat[1], rrsp[1], rlst[1]);
      end
   endtask

   task automatic test_strobe_wlast();
      logic [1:0] r; logic [7:0] id; int lat;
      wbuf[0] = 32'hFFFF_FFFF;
      do_write(16'h0200, 8'd0, 2'b01, 8'h07, 4'hF, -1, r, id);
      wbuf[0] = 32'h1122_3344;
      do_write(16'h0200, 8'd0, 2'b01, 8'h07, 4'b0101, -1, r, id);
      checks++; if (r !== 2'b00) begin errors++; $display("FAIL strb_bresp got=%b exp=00", r); end
      do_read(16'h0200, 8'd0, 2'b01, 8'h08, lat);
      checks++; if (rdat[0] !== 32'hFF22_FF44 || rlst[0] !== 1'b1) begin
         errors++; $display("FAIL strb_data got=%h/%b exp=ff22ff44/1", rdat[0], rlst[0]);
      end
      wbuf[0] = 32'hE0; wbuf[1] = 32'hE1;
      do_write(16'h0204, 8'd1, 2'b01, 8'h09, 4'hF, 0, r, id);
      checks++; if (r !== 2'b10) begin errors++; $display("FAIL wlast_bresp got=%b exp=10", r); end
      do_read(16'h0204, 8'd1, 2'b01, 8'h0A, lat);
      checks++; if (rdat[0] !== 32'hE0 || rdat[1] !== 32'hE1) begin
         errors++; $display("FAIL wlast_data got=%h,%h exp=000000e0,000000e1", rdat[0], rdat[1]);
      end
   endtask

   task automatic test_reset_mid_read();
      int lat;
      rready = 1'b0;
      ar_send(16'h0100, 8'd7, 2'b01, 8'h66);
      repeat (8) step();
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_rvalid got=%b exp=1", rvalid); end
      rst_n = 1'b0;
      step();
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got=%b exp=0", rvalid); end
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL mid_arready got=%b exp=0", arready); end
      rst_n = 1'b1;
      step();
      checks++; if (arready !== 1'b1 || awready !== 1'b1) begin
         errors++; $display("FAIL mid_ready got=%b/%b exp=1/1", arready, awready);
      end
      repeat (10) step();
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_flushed got=rvalid %b exp=0", rvalid); end
      do_read(16'h0100, 8'd3, 2'b01, 8'h77, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL mid_latency got=%0d exp=5", lat); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdat[i] !== 32'hC000_0000 + 32'(i) || rids[i] !== 8'h77) begin
            errors++; $display("FAIL mid_data%0d got=%h/%h exp=%h/77", i, rdat[i], rids[i], 32'hC000_0000 + 32'(i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_wrap();
      test_backpressure();
      test_out_of_range();
      test_strobe_wlast();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
